// File: rtl/imu_init_sequencer.sv
// imu_init_sequencer
// Command source for a single-register I2C write engine. After go is accepted, it
// steps through a fixed MPU9250 configuration table. For each entry it presents
// the device, register and data, pulses i2c_start, waits for the engine to drop
// and then raise i2c_done, and then waits a settle delay that depends on the entry.
// Each transfer is guarded by an accept timeout and a transfer timeout, and each
// entry gets a bounded number of retries. A NACK from the engine returns it to
// idle with done high, so the sequencer cannot tell a NACK from a success.
module imu_init_sequencer #(
  parameter logic [6:0] DEV_ADDR       = 7'h68,
  parameter int         ACCEPT_TIMEOUT = 16,
  parameter int         XFER_TIMEOUT   = 128,
  parameter int         MAX_RETRY      = 3,
  parameter int         RESET_DELAY    = 20000,
  parameter int         SETTLE_DELAY   = 200
) (
  input  logic       clock_for_sys,
  input  logic       reset,
  input  logic       go,
  input  logic       i2c_done,
  output logic       i2c_start,
  output logic [6:0] device_address,
  output logic [7:0] register_address,
  output logic [7:0] data_in,
  output logic       busy,
  output logic       init_done,
  output logic       error,
  output logic [2:0] step
);

  localparam int NUM_ENTRIES = 6;
  localparam int TIMER_W     = 15;
  localparam int RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TIMER_W-1:0] ACCEPT_LAST = TIMER_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] XFER_LAST   = TIMER_W'(XFER_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] RESET_DLY   = TIMER_W'(RESET_DELAY);
  localparam logic [TIMER_W-1:0] SETTLE_DLY  = TIMER_W'(SETTLE_DELAY);
  localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRY);
  localparam logic [2:0]         LAST_STEP   = 3'(NUM_ENTRIES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_DELAY,
    S_NEXT,
    S_RETRY,
    S_FINISHED,
    S_FAULT
  } state_t;

  state_t               state_q, state_d;
  logic                 i2c_start_q, i2c_start_d;
  logic                 busy_q, busy_d;
  logic                 init_done_q, init_done_d;
  logic                 error_q, error_d;
  logic [2:0]           step_q, step_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [6:0]           device_address_q, device_address_d;
  logic [7:0]           register_address_q, register_address_d;
  logic [7:0]           data_in_q, data_in_d;

  // Table contents for the current step.
  logic [7:0]           tbl_reg;
  logic [7:0]           tbl_data;
  logic [TIMER_W-1:0]   tbl_delay;

  // Configuration table lookup. Entry 0 resets the device, so it needs the long delay.
  always_comb begin
    tbl_reg   = 8'h00;
    tbl_data  = 8'h00;
    tbl_delay = SETTLE_DLY;
    case (step_q)
      3'd0: begin tbl_reg = 8'h6B; tbl_data = 8'h80; tbl_delay = RESET_DLY;  end
      3'd1: begin tbl_reg = 8'h6B; tbl_data = 8'h01; tbl_delay = SETTLE_DLY; end
      3'd2: begin tbl_reg = 8'h1A; tbl_data = 8'h03; tbl_delay = SETTLE_DLY; end
      3'd3: begin tbl_reg = 8'h1B; tbl_data = 8'h00; tbl_delay = SETTLE_DLY; end
      3'd4: begin tbl_reg = 8'h1C; tbl_data = 8'h00; tbl_delay = SETTLE_DLY; end
      3'd5: begin tbl_reg = 8'h19; tbl_data = 8'h04; tbl_delay = SETTLE_DLY; end
      default: begin tbl_reg = 8'h00; tbl_data = 8'h00; tbl_delay = SETTLE_DLY; end
    endcase
  end

  // Next-state and registered-output logic for the sequencer FSM.
  always_comb begin
    state_d            = state_q;
    i2c_start_d        = i2c_start_q;
    busy_d             = busy_q;
    init_done_d        = init_done_q;
    error_d            = error_q;
    step_d             = step_q;
    retry_d            = retry_q;
    timer_d            = timer_q;
    device_address_d   = DEV_ADDR;
    register_address_d = register_address_q;
    data_in_d          = data_in_q;

    case (state_q)
      // go is accepted only from these resting states. Accepting it clears the
      // sticky flags and restarts the sequence at entry 0.
      S_IDLE, S_FINISHED, S_FAULT: begin
        if (go) begin
          step_d      = 3'd0;
          retry_d     = '0;
          timer_d     = '0;
          busy_d      = 1'b1;
          init_done_d = 1'b0;
          error_d     = 1'b0;
          state_d     = S_LOAD;
        end
      end

      // Latch the entry once. The engine inputs then stay stable across retries.
      S_LOAD: begin
        register_address_d = tbl_reg;
        data_in_d          = tbl_data;
        state_d            = S_ISSUE;
      end

      S_ISSUE: begin
        i2c_start_d = 1'b1;
        timer_d     = '0;
        state_d     = S_WAIT_ACCEPT;
      end

      // The engine accepts the start by dropping done.
      S_WAIT_ACCEPT: begin
        if (!i2c_done) begin
          i2c_start_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT_DONE;
        end else if (timer_q == ACCEPT_LAST) begin
          i2c_start_d = 1'b0;
          state_d     = S_RETRY;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      // done rising again ends the transfer. A NACK also ends it this way.
      S_WAIT_DONE: begin
        if (i2c_done) begin
          timer_d = tbl_delay;
          state_d = S_DELAY;
        end else if (timer_q == XFER_LAST) begin
          state_d = S_RETRY;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      // Entered with timer = D. Leaving when 1 is seen gives exactly D cycles here.
      S_DELAY: begin
        if (timer_q <= TIMER_W'(1)) begin
          timer_d = '0;
          state_d = S_NEXT;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end

      S_NEXT: begin
        retry_d = '0;
        if (step_q == LAST_STEP) begin
          init_done_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_FINISHED;
        end else begin
          step_d  = step_q + 3'd1;
          state_d = S_LOAD;
        end
      end

      // Passing through ISSUE keeps start low for at least one cycle before it is re-asserted.
      S_RETRY: begin
        i2c_start_d = 1'b0;
        if (retry_q == RETRY_LAST) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_FAULT;
        end else begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = S_ISSUE;
        end
      end

      default: begin
        i2c_start_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset abandons any transfer in flight.
  always_ff @(posedge clock_for_sys) begin
    if (reset) begin
      state_q            <= S_IDLE;
      i2c_start_q        <= 1'b0;
      busy_q             <= 1'b0;
      init_done_q        <= 1'b0;
      error_q            <= 1'b0;
      step_q             <= 3'd0;
      retry_q            <= '0;
      timer_q            <= '0;
      device_address_q   <= DEV_ADDR;
      register_address_q <= 8'h00;
      data_in_q          <= 8'h00;
    end else begin
      state_q            <= state_d;
      i2c_start_q        <= i2c_start_d;
      busy_q             <= busy_d;
      init_done_q        <= init_done_d;
      error_q            <= error_d;
      step_q             <= step_d;
      retry_q            <= retry_d;
      timer_q            <= timer_d;
      device_address_q   <= device_address_d;
      register_address_q <= register_address_d;
      data_in_q          <= data_in_d;
    end
  end

  assign i2c_start        = i2c_start_q;
  assign busy             = busy_q;
  assign init_done        = init_done_q;
  assign error            = error_q;
  assign step             = step_q;
  assign device_address   = device_address_q;
  assign register_address = register_address_q;
  assign data_in          = data_in_q;

endmodule

// File: tb/tb_imu_init_sequencer.sv
// Testbench for imu_init_sequencer. An engine model with random latencies and
// configurable faults drives i2c_done. Every i2c_start pulse is logged, and the
// log is compared against the expected register/data order, gaps and flags.
module tb_imu_init_sequencer;

  localparam int RESET_DELAY  = 20000;
  localparam int SETTLE_DELAY = 200;
  localparam int ACC_TIMEOUT  = 16;

  logic       clock_for_sys = 1'b0;
  logic       reset = 1'b1;
  logic       go = 1'b0;
  logic       i2c_done;
  logic       i2c_start;
  logic [6:0] device_address;
  logic [7:0] register_address;
  logic [7:0] data_in;
  logic       busy;
  logic       init_done;
  logic       error;
  logic [2:0] step;

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;

  // Expected table contents (register, data, post-entry delay).
  int ref_reg[6]   = '{'h6B, 'h6B, 'h1A, 'h1B, 'h1C, 'h19};
  int ref_data[6]  = '{'h80, 'h01, 'h03, 'h00, 'h00, 'h04};
  int ref_delay[6] = '{RESET_DELAY, SETTLE_DELAY, SETTLE_DELAY, SETTLE_DELAY, SETTLE_DELAY, SETTLE_DELAY};

  imu_init_sequencer dut (
    .clock_for_sys    (clock_for_sys),
    .reset            (reset),
    .go               (go),
    .i2c_done         (i2c_done),
    .i2c_start        (i2c_start),
    .device_address   (device_address),
    .register_address (register_address),
    .data_in          (data_in),
    .busy             (busy),
    .init_done        (init_done),
    .error            (error),
    .step             (step)
  );

  always #5 clock_for_sys = ~clock_for_sys;

  // Free-running cycle counter. It is stable whenever it is read on the falling edge.
  always @(posedge clock_for_sys) cycle_cnt <= cycle_cnt + 1;

  // Log of start pulses: rise time, presented values, high width and the low gap before each rise.
  int   rise_cyc[$];
  int   rise_reg[$];
  int   rise_data[$];
  int   rise_step[$];
  int   high_w[$];
  int   low_gap[$];
  int   done_rise[$];
  logic start_prev = 1'b0;
  int   last_rise = 0;
  int   last_fall = -1000;

  initial begin
    forever begin
      @(negedge clock_for_sys);
      if (i2c_start === 1'b1 && start_prev === 1'b0) begin
        rise_cyc.push_back(cycle_cnt);
        rise_reg.push_back(int'(register_address));
        rise_data.push_back(int'(data_in));
        rise_step.push_back(int'(step));
        low_gap.push_back(cycle_cnt - last_fall);
        last_rise = cycle_cnt;
      end
      if (i2c_start === 1'b0 && start_prev === 1'b1) begin
        high_w.push_back(cycle_cnt - last_rise);
        last_fall = cycle_cnt;
      end
      start_prev = i2c_start;
    end
  end

  // Engine model. Index k is the number of completed transfers.
  // never_accept_idx: the engine ignores starts for that transfer.
  // hang_idx: on its first attempt, done stays low for 200 cycles.
  int never_accept_idx = -1;
  int hang_idx = -1;
  bit hang_used = 1'b0;
  int done_count = 0;

  initial begin
    int acc;
    int dur;
    i2c_done = 1'b1;
    forever begin
      @(negedge clock_for_sys);
      if (i2c_start === 1'b1 && done_count != never_accept_idx) begin
        acc = $urandom_range(1, 8);
        dur = $urandom_range(20, 100);
        repeat (acc) @(negedge clock_for_sys);
        i2c_done = 1'b0;
        if (done_count == hang_idx && !hang_used) begin
          hang_used = 1'b1;
          dur = 200;
        end
        repeat (dur) @(negedge clock_for_sys);
        i2c_done = 1'b1;
        done_rise.push_back(cycle_cnt);
        done_count++;
      end
    end
  end

  task automatic clear_logs();
    rise_cyc.delete();
    rise_reg.delete();
    rise_data.delete();
    rise_step.delete();
    high_w.delete();
    low_gap.delete();
    done_rise.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go = 1'b0;
    repeat (3) @(negedge clock_for_sys);
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b expected 0", i2c_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %0b expected 0", init_done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %0b expected 0", error); end
    checks++; if (step !== 3'd0) begin errors++; $display("FAIL reset_step got %0d expected 0", step); end
    checks++; if (device_address !== 7'h68) begin errors++; $display("FAIL reset_dev got %0h expected 68", device_address); end
    checks++; if (register_address !== 8'h00) begin errors++; $display("FAIL reset_reg got %0h expected 0", register_address); end
    checks++; if (data_in !== 8'h00) begin errors++; $display("FAIL reset_data got %0h expected 0", data_in); end
    reset = 1'b0;
    repeat (5) @(negedge clock_for_sys);
    checks++; if (busy !== 1'b0 || i2c_start !== 1'b0) begin errors++; $display("FAIL idle_quiet got busy=%0b start=%0b expected 0/0", busy, i2c_start); end
    $display("test_reset done");
  endtask

  task automatic test_normal_sequence();
    int g;
    int n;
    int prev_step;
    int fin;
    bit mono_ok;
    clear_logs();
    never_accept_idx = -1;
    hang_idx = -1;
    done_count = 0;
    g = cycle_cnt;
    go = 1'b1;
    @(negedge clock_for_sys);
    go = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL norm_busy_on got %0b expected 1", busy); end
    n = 0;
    prev_step = int'(step);
    mono_ok = 1'b1;
    // Random go pulses while busy must be ignored.
    while (busy === 1'b1 && n < 30000) begin
      go = ($urandom_range(0, 299) == 0);
      @(negedge clock_for_sys);
      n++;
      if (int'(step) < prev_step) mono_ok = 1'b0;
      prev_step = int'(step);
    end
    go = 1'b0;
    fin = cycle_cnt;
    checks++; if (n >= 30000) begin errors++; $display("FAIL norm_timeout got busy=%0b expected 0 within 30000 cycles", busy); end
    checks++; if (mono_ok !== 1'b1) begin errors++; $display("FAIL norm_step_monotonic got %0b expected 1", mono_ok); end
    checks++; if (rise_cyc.size() != 6) begin errors++; $display("FAIL norm_start_count got %0d expected 6", rise_cyc.size()); end
    if (rise_cyc.size() > 0) begin
      checks++; if (rise_cyc[0] - g != 3) begin errors++; $display("FAIL norm_first_latency got %0d expected 3", rise_cyc[0] - g); end
    end
    if (rise_cyc.size() == 6 && done_rise.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rise_reg[i] != ref_reg[i] || rise_data[i] != ref_data[i] || rise_step[i] != i) begin
          errors++;
          $display("FAIL norm_entry%0d got reg=%0h data=%0h step=%0d expected reg=%0h data=%0h step=%0d",
                   i, rise_reg[i], rise_data[i], rise_step[i], ref_reg[i], ref_data[i], i);
        end
      end
      // Done-rise to next start: 1 cycle to notice done, D delay cycles, then NEXT, LOAD, ISSUE.
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (rise_cyc[i+1] - done_rise[i] != ref_delay[i] + 4) begin
          errors++;
          $display("FAIL norm_gap%0d got %0d expected %0d", i, rise_cyc[i+1] - done_rise[i], ref_delay[i] + 4);
        end
      end
      // Last entry: 1 + delay + NEXT before FINISHED drops busy.
      checks++; if (fin - done_rise[5] != SETTLE_DELAY + 2) begin errors++; $display("FAIL norm_finish_latency got %0d expected %0d", fin - done_rise[5], SETTLE_DELAY + 2); end
    end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL norm_init_done got %0b expected 1", init_done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL norm_error got %0b expected 0", error); end
    checks++; if (step !== 3'd5) begin errors++; $display("FAIL norm_step got %0d expected 5", step); end
    checks++; if (device_address !== 7'h68) begin errors++; $display("FAIL norm_dev got %0h expected 68", device_address); end
    $display("test_normal_sequence done: %0d starts", rise_cyc.size());
  endtask

  task automatic test_accept_timeout();
    int n;
    clear_logs();
    never_accept_idx = 2;
    hang_idx = -1;
    done_count = 0;
    go = 1'b1;
    @(negedge clock_for_sys);
    go = 1'b0;
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL acc_go_clears_done got %0b expected 0", init_done); end
    n = 0;
    while (busy === 1'b1 && n < 30000) begin
      @(negedge clock_for_sys);
      n++;
    end
    checks++; if (n >= 30000) begin errors++; $display("FAIL acc_timeout_wait got busy=%0b expected 0 within 30000 cycles", busy); end
    checks++; if (rise_cyc.size() != 6) begin errors++; $display("FAIL acc_start_count got %0d expected 6", rise_cyc.size()); end
    if (rise_cyc.size() == 6 && high_w.size() == 6) begin
      for (int i = 2; i < 6; i++) begin
        checks++;
        if (rise_reg[i] != 'h1A || rise_data[i] != 'h03 || rise_step[i] != 2) begin
          errors++;
          $display("FAIL acc_attempt%0d got reg=%0h data=%0h step=%0d expected reg=1a data=3 step=2", i - 2, rise_reg[i], rise_data[i], rise_step[i]);
        end
        checks++;
        if (high_w[i] != ACC_TIMEOUT) begin
          errors++;
          $display("FAIL acc_high_width%0d got %0d expected %0d", i - 2, high_w[i], ACC_TIMEOUT);
        end
        if (i > 2) begin
          checks++;
          if (low_gap[i] < 1) begin errors++; $display("FAIL acc_low_gap%0d got %0d expected >=1", i - 2, low_gap[i]); end
        end
      end
    end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL acc_error got %0b expected 1", error); end
    checks++; if (step !== 3'd2) begin errors++; $display("FAIL acc_step got %0d expected 2", step); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL acc_busy got %0b expected 0", busy); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL acc_init_done got %0b expected 0", init_done); end
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL acc_start_low got %0b expected 0", i2c_start); end
    $display("test_accept_timeout done: %0d starts", rise_cyc.size());
  endtask

  task automatic test_fault_rerun_xfer_timeout();
    int n;
    int exp_idx[7] = '{0, 1, 1, 2, 3, 4, 5};
    clear_logs();
    never_accept_idx = -1;
    hang_idx = 1;
    hang_used = 1'b0;
    done_count = 0;
    go = 1'b1;
    @(negedge clock_for_sys);
    go = 1'b0;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rerun_error_cleared got %0b expected 0", error); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rerun_busy got %0b expected 1", busy); end
    checks++; if (step !== 3'd0) begin errors++; $display("FAIL rerun_step0 got %0d expected 0", step); end
    n = 0;
    while (busy === 1'b1 && n < 30000) begin
      @(negedge clock_for_sys);
      n++;
    end
    checks++; if (n >= 30000) begin errors++; $display("FAIL rerun_wait got busy=%0b expected 0 within 30000 cycles", busy); end
    checks++; if (rise_cyc.size() != 7) begin errors++; $display("FAIL rerun_start_count got %0d expected 7", rise_cyc.size()); end
    if (rise_cyc.size() == 7) begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (rise_reg[i] != ref_reg[exp_idx[i]] || rise_data[i] != ref_data[exp_idx[i]] || rise_step[i] != exp_idx[i]) begin
          errors++;
          $display("FAIL rerun_start%0d got reg=%0h data=%0h step=%0d expected reg=%0h data=%0h step=%0d",
                   i, rise_reg[i], rise_data[i], rise_step[i], ref_reg[exp_idx[i]], ref_data[exp_idx[i]], exp_idx[i]);
        end
      end
    end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL rerun_init_done got %0b expected 1", init_done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rerun_error got %0b expected 0", error); end
    checks++; if (step !== 3'd5) begin errors++; $display("FAIL rerun_step got %0d expected 5", step); end
    $display("test_fault_rerun_xfer_timeout done: %0d starts", rise_cyc.size());
  endtask

  task automatic test_reset_mid_transfer();
    int n;
    clear_logs();
    never_accept_idx = -1;
    hang_idx = -1;
    done_count = 0;
    go = 1'b1;
    @(negedge clock_for_sys);
    go = 1'b0;
    // Wait until entry 3 has been accepted, i.e. the sequencer is waiting for done.
    n = 0;
    while (!(rise_cyc.size() >= 4 && i2c_start === 1'b0) && n < 30000) begin
      @(negedge clock_for_sys);
      n++;
    end
    checks++; if (n >= 30000) begin errors++; $display("FAIL mid_reach_entry3 got %0d starts expected 4 within 30000 cycles", rise_cyc.size()); end
    checks++; if (step !== 3'd3 || i2c_done !== 1'b0) begin errors++; $display("FAIL mid_in_wait_done got step=%0d done=%0b expected 3/0", step, i2c_done); end
    reset = 1'b1;
    @(negedge clock_for_sys);
    checks++; if (i2c_start !== 1'b0) begin errors++; $display("FAIL mid_reset_start got %0b expected 0", i2c_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %0b expected 0", busy); end
    checks++; if (step !== 3'd0) begin errors++; $display("FAIL mid_reset_step got %0d expected 0", step); end
    checks++; if (register_address !== 8'h00 || data_in !== 8'h00) begin errors++; $display("FAIL mid_reset_regdata got %0h/%0h expected 0/0", register_address, data_in); end
    reset = 1'b0;
    n = 0;
    while (i2c_done !== 1'b1 && n < 200) begin
      @(negedge clock_for_sys);
      n++;
    end
    repeat (3) @(negedge clock_for_sys);
    clear_logs();
    go = 1'b1;
    @(negedge clock_for_sys);
    go = 1'b0;
    n = 0;
    while (rise_cyc.size() == 0 && n < 20) begin
      @(negedge clock_for_sys);
      n++;
    end
    checks++; if (rise_cyc.size() == 0) begin errors++; $display("FAIL mid_restart_start got 0 starts expected 1 within 20 cycles"); end
    if (rise_cyc.size() > 0) begin
      checks++;
      if (rise_reg[0] != 'h6B || rise_data[0] != 'h80 || rise_step[0] != 0) begin
        errors++;
        $display("FAIL mid_restart_entry got reg=%0h data=%0h step=%0d expected reg=6b data=80 step=0", rise_reg[0], rise_data[0], rise_step[0]);
      end
    end
    $display("test_reset_mid_transfer done");
  endtask

  initial begin
    @(negedge clock_for_sys);
    test_reset();
    test_normal_sequence();
    test_accept_timeout();
    test_fault_rerun_xfer_timeout();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
